// File: rtl/inject.sv
// Local injection stage: FIFO-buffers local flits and inserts the head flit into one free channel per cycle.
// Optional starvation monitor enabled by defining INJECT_STARVE_MON_EN.
package inject_pkg;
    typedef struct packed {
        logic       vld;
        logic       golden;
        logic       silver;
        logic [1:0] dst;
        logic [3:0] flit_id;
        logic [7:0] payload;
    } flit_int_t;
endpackage

module inject
    import inject_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int STARVE_TH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 rand_num,
    input  flit_int_t                  din_0,
    input  flit_int_t                  din_1,
    input  flit_int_t                  din_2,
    input  flit_int_t                  din_3,
    input  flit_int_t                  local_din,
    input  logic                       local_vld,
    output logic                       local_rdy,
    output flit_int_t                  dout_0,
    output flit_int_t                  dout_1,
    output flit_int_t                  dout_2,
    output flit_int_t                  dout_3,
    output logic [3:0]                 inj_vec,
    output logic [$clog2(DEPTH+1)-1:0] fifo_cnt,
    output logic                       starve
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_C    = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE_C = CW'(1);
    localparam logic [AW-1:0] PTR_ONE_C = AW'(1);

    flit_int_t     mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] cnt_r;

    flit_int_t     din_s [4];
    flit_int_t     dout_s [4];
    flit_int_t     inj_flit_s;
    logic [3:0]    free_s;
    logic [3:0]    win_s;
    logic [3:0]    inj_vec_s;
    logic [1:0]    sel_idx_s;
    logic          found_s;
    logic          empty_s;
    logic          push_s;
    logic          pop_s;

    assign din_s[0] = din_0;
    assign din_s[1] = din_1;
    assign din_s[2] = din_2;
    assign din_s[3] = din_3;

    assign empty_s   = (cnt_r == '0);
    assign local_rdy = (cnt_r != FULL_C);
    assign push_s    = local_vld && (cnt_r != FULL_C);
    assign pop_s     = |inj_vec_s;
    assign fifo_cnt  = cnt_r;
    assign inj_vec   = inj_vec_s;

    // Free-slot vector from channel valid bits
    always_comb begin
        free_s = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            free_s[k] = !din_s[k].vld;
        end
    end

    // Rotating first-free search starting at rand_num; gated off when nothing is queued
    always_comb begin
        win_s     = 4'b0000;
        found_s   = 1'b0;
        sel_idx_s = 2'd0;
        for (int i = 0; i < 4; i++) begin
            sel_idx_s = rand_num + 2'(i);
            if (!found_s && free_s[sel_idx_s]) begin
                win_s[sel_idx_s] = 1'b1;
                found_s          = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        if (empty_s) begin
            inj_vec_s = 4'b0000;
        end else begin
            inj_vec_s = win_s;
        end
    end

    // Injected copy of the head: marked valid, priority flags cleared
    always_comb begin
        inj_flit_s        = mem_r[rd_ptr_r];
        inj_flit_s.vld    = 1'b1;
        inj_flit_s.golden = 1'b0;
        inj_flit_s.silver = 1'b0;
    end

    // Channel pass-through with the winning slot replaced
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            if (inj_vec_s[k]) begin
                dout_s[k] = inj_flit_s;
            end else begin
                dout_s[k] = din_s[k];
            end
        end
    end

    assign dout_0 = dout_s[0];
    assign dout_1 = dout_s[1];
    assign dout_2 = dout_s[2];
    assign dout_3 = dout_s[3];

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= local_din;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CNT_ONE_C;
                2'b01:   cnt_r <= cnt_r - CNT_ONE_C;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

`ifdef INJECT_STARVE_MON_EN
    localparam logic [7:0] TH_C = 8'(STARVE_TH);

    logic [7:0] stv_cnt_r;
    logic [7:0] stv_cnt_nxt_s;
    logic       starve_r;

    // Blocked-head counter, saturating at the threshold
    always_comb begin
        stv_cnt_nxt_s = stv_cnt_r;
        if (empty_s || pop_s) begin
            stv_cnt_nxt_s = 8'd0;
        end else if (stv_cnt_r == TH_C) begin
            stv_cnt_nxt_s = stv_cnt_r;
        end else begin
            stv_cnt_nxt_s = stv_cnt_r + 8'd1;
        end
    end

    // Starvation state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stv_cnt_r <= 8'd0;
            starve_r  <= 1'b0;
        end else begin
            stv_cnt_r <= stv_cnt_nxt_s;
            starve_r  <= (stv_cnt_nxt_s == TH_C);
        end
    end

    assign starve = starve_r;
`else
    assign starve = 1'b0;
`endif

endmodule
